// File: rtl/sound_event_queue_pkg.sv
// Shared constants and types for the play_sound event queue.
package sound_event_queue_pkg;

  localparam logic [7:0] CMD_PLAY_SOUND = 8'hfa;
  localparam logic [7:0] DROPS_MAX      = 8'hff;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StHold    = 2'd2
  } ho_state_e;

endpackage

// File: rtl/sound_event_queue_if.sv
// CPU-side push/status and consumer-side request signals of the sound event queue.
interface sound_event_queue_if #(
  parameter int unsigned LOG2_DEPTH = 4
);
  logic [7:0]          cpu_wdata;
  logic                cpu_push;
  logic                cpu_clr;
  logic [LOG2_DEPTH:0] stat_level;
  logic                stat_full;
  logic                stat_ovf;
  logic [7:0]          stat_drops;
  logic [7:0]          req_sound_id;
  logic                req_valid;
  logic                req_ready;

  modport master (
    input  cpu_wdata, cpu_push, cpu_clr, req_ready,
    output stat_level, stat_full, stat_ovf, stat_drops, req_sound_id, req_valid
  );

  modport slave (
    output cpu_wdata, cpu_push, cpu_clr, req_ready,
    input  stat_level, stat_full, stat_ovf, stat_drops, req_sound_id, req_valid
  );
endinterface

// File: rtl/sound_event_queue_fifo_ram.sv
// 2**AW x 8 RAM, one write port and one registered read port (EBR or distributed RAM).
module sound_fifo_ram #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sound_event_queue.sv
// In-order play_sound event queue with a programmable hold-off between presented events.
module sound_event_queue
  import sound_event_queue_pkg::*;
#(
  parameter int unsigned LOG2_DEPTH = 4,
  parameter int unsigned HOLDOFF    = 0,
  parameter int unsigned HO_W       = 16
) (
  input logic                 clk,
  input logic                 rst,
  sound_event_queue_if.master bus
);
  typedef logic [LOG2_DEPTH-1:0] ptr_t;
  typedef logic [LOG2_DEPTH:0]   lvl_t;

  localparam lvl_t            DEPTH_LVL = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic [HO_W-1:0] HO_LOAD   = (HOLDOFF == 0) ? '0 : HO_W'(HOLDOFF - 1);

  ho_state_e       state_q;
  ptr_t            wr_ptr_q, rd_ptr_q, rd_ptr_d;
  lvl_t            level_q, level_nxt;
  logic [HO_W-1:0] ho_cnt_q;
  logic            valid_q, full_q, ovf_q, byp_hit_q;
  logic [7:0]      id_q, drops_q, byp_q, ram_rdata, head_data;
  logic            transfer, push_ok, drop, ram_empty, leaving, load;

  // rd_ptr addresses the oldest entry not yet moved into the output register.
  always_comb begin
    transfer  = valid_q & bus.req_ready;
    push_ok   = bus.cpu_push & ~bus.cpu_clr & ((level_q != DEPTH_LVL) | transfer);
    drop      = bus.cpu_push & ~bus.cpu_clr & (level_q == DEPTH_LVL) & ~transfer;
    level_nxt = level_q + lvl_t'(push_ok) - lvl_t'(transfer);
    ram_empty = (level_q == lvl_t'(state_q == StPresent));
    leaving   = (state_q == StIdle) | ((state_q == StHold) & (ho_cnt_q == '0)) |
                (transfer & (HOLDOFF == 0));
    load      = leaving & (level_nxt != '0) & ~bus.cpu_clr;
    rd_ptr_d  = (rst | bus.cpu_clr) ? '0 : rd_ptr_q + ptr_t'(load);
    // Read-before-write RAM: a write to the prefetch address last cycle is taken from byp_q.
    head_data = ram_empty ? bus.cpu_wdata : (byp_hit_q ? byp_q : ram_rdata);
  end

  sound_fifo_ram #(
    .AW(LOG2_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (push_ok),
    .waddr(wr_ptr_q),
    .wdata(bus.cpu_wdata),
    .raddr(rd_ptr_d),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst | bus.cpu_clr) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ho_cnt_q  <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drops_q   <= '0;
      id_q      <= '0;
      byp_q     <= '0;
      byp_hit_q <= 1'b0;
    end else begin
      level_q   <= level_nxt;
      full_q    <= (level_nxt == DEPTH_LVL);
      rd_ptr_q  <= rd_ptr_d;
      byp_q     <= bus.cpu_wdata;
      byp_hit_q <= push_ok & (wr_ptr_q == rd_ptr_d);
      if (push_ok) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drops_q != DROPS_MAX) drops_q <= drops_q + 8'd1;
      end
      if (load) id_q <= head_data;
      case (state_q)
        StIdle: begin
          if (load) begin
            state_q <= StPresent;
            valid_q <= 1'b1;
          end
        end
        StPresent: begin
          if (transfer) begin
            if (HOLDOFF != 0) begin
              state_q  <= StHold;
              valid_q  <= 1'b0;
              ho_cnt_q <= HO_LOAD;
            end else if (!load) begin
              state_q <= StIdle;
              valid_q <= 1'b0;
            end
          end
        end
        StHold: begin
          if (ho_cnt_q != '0) begin
            ho_cnt_q <= ho_cnt_q - HO_W'(1);
          end else if (load) begin
            state_q <= StPresent;
            valid_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_valid    = valid_q;
  assign bus.req_sound_id = id_q;
  assign bus.stat_level   = level_q;
  assign bus.stat_full    = full_q;
  assign bus.stat_ovf     = ovf_q;
  assign bus.stat_drops   = drops_q;
endmodule
